intersection_sequencer: RTL and testbench
=========================================

INTERSECTION_SEQUENCER -- requirements
Module: intersection_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- YEL_T, 5, yellow phase duration in ticks.
- CLR_T, 2, all-red clearance duration in ticks.
- WALK_T, 10, pedestrian walk duration in ticks.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- tick, in, 1, one-clk pulse per second (1 Hz time base); the only timing event.
- mode, in, 2, operating mode: 00 normal, 01 night flash, 10 all-red hold, 11 treated as 00.
- green_a, in, 8, approach A green duration in ticks; sampled on entry to A_GRN.
- green_b, in, 8, approach B green duration in ticks; sampled on entry to B_GRN.
- ped_req, in, 1, pedestrian request; any clk with ped_req=1 sets the pending latch.
- ped_ack, out, 1, one-clk pulse on entry to PED.
- a_r/a_y/a_g, out, 1 each, approach A lamps.
- b_r/b_y/b_g, out, 1 each, approach B lamps.
- walk, out, 1, pedestrian walk lamp.
- count, out, 8, remaining ticks in the current timed phase.

Function
REQ-003 States: A_GRN, A_YEL, AR1, B_GRN, B_YEL, AR2, PED, FLASH, HOLD. All outputs are registered.
REQ-004 Phase entry loads count with the phase duration: green_a, YEL_T, CLR_T, green_b, YEL_T, CLR_T or WALK_T. A duration of 0 loads 1.
REQ-005 On each tick in a timed phase: if count>1, decrement count; if count==1, the phase expires and the next phase loads on that same clk. A phase of duration N lasts exactly N ticks.
REQ-006 Normal sequence is A_GRN->A_YEL->AR1->B_GRN->B_YEL->AR2.
- AR2 expiry goes to PED if the pending latch is set, else to A_GRN.
- PED expiry goes to A_GRN.
REQ-007 Lamps per state:
- A_GRN: a_g=1, b_r=1.
- A_YEL: a_y=1, b_r=1.
- B_GRN: b_g=1, a_r=1.
- B_YEL: b_y=1, a_r=1.
- AR1, AR2, HOLD: a_r=b_r=1.
- PED: a_r=b_r=walk=1.
- All other lamps are 0. No state drives a green on both approaches.
REQ-008 Pending latch:
- Set by ped_req=1 in any clk.
- Cleared on the clk of entry to PED or FLASH; set takes priority over clear in the same clk.
- Held through HOLD.
REQ-009 With mode!=00 in A_GRN or B_GRN, the next tick truncates green and enters the matching yellow. Yellow and all-red phases always run to completion.
REQ-010 At AR1 or AR2 expiry: mode=01 enters FLASH; mode=10 enters HOLD; otherwise follow REQ-006.
REQ-011 FLASH behaviour:
- a_y=b_y=flash bit; all other lamps 0; count=0.
- The flash bit is cleared on entry and toggles on each tick.
REQ-012 HOLD: count=0.
REQ-013 In FLASH or HOLD, mode=00 (or 11) on a tick enters AR2 with count=CLR_T.
REQ-014 In FLASH or HOLD, a change directly between modes 01 and 10 on a tick switches between FLASH and HOLD.
REQ-015 Without a tick, state, count and lamps hold; ped_req still latches.

Reset
REQ-016 rst=0 forces, asynchronously:
- state=AR2, count=CLR_T, a_r=b_r=1.
- All other lamps, walk and ped_ack are 0.
- The pending latch and flash bit are 0.
REQ-017 Reset asserted mid-phase aborts the phase immediately. After release, the first tick decrements count from CLR_T.

Verification
REQ-018 Release rst, green_a=8, green_b=6, mode=00, no ped -> cycle AR2(2) A_GRN(8) A_YEL(5) AR1(2) B_GRN(6) B_YEL(5) AR2(2), period 28 ticks; count values match each phase.
REQ-019 ped_req one-clk pulse during B_GRN -> after AR2, PED for 10 ticks with walk=1, ped_ack one-clk pulse at entry, then A_GRN; the next AR2 goes straight to A_GRN.
REQ-020 mode=01 asserted at A_GRN count=5 -> next tick enters A_YEL (5), then AR1 (2), then FLASH; a_y=b_y toggle each tick; mode=00 -> AR2 (2) then A_GRN.
REQ-021 green_a=0 -> A_GRN lasts exactly 1 tick; tick held 0 for 100 clks in B_YEL -> count frozen.
REQ-022 rst pulsed low during A_GRN count=3 -> immediate all-red, count=2, pending latch cleared.
REQ-023 mode=10 during B_GRN -> B_YEL, AR2, HOLD with all red; ped_req in HOLD is retained; mode=00 -> AR2, then PED.

Source files
------------

// File: rtl/intersection_sequencer.sv
// Two-approach intersection sequencer with pedestrian phase, night flash and
// all-red hold. All phase timing is driven by the 1 Hz tick; every output is
// a register.
//
// state  | meaning
// -------+-----------------------------------------------
// A_GRN  | approach A green, B red (duration green_a)
// A_YEL  | approach A yellow, B red (YEL_T)
// AR1    | all-red clearance after A (CLR_T)
// B_GRN  | approach B green, A red (duration green_b)
// B_YEL  | approach B yellow, A red (YEL_T)
// AR2    | all-red clearance after B, reset state (CLR_T)
// PED    | all-red with walk lamp (WALK_T)
// FLASH  | night flash, both yellows blink on tick
// HOLD   | all-red hold, untimed
module intersection_sequencer #(
    parameter int YEL_T  = 5,
    parameter int CLR_T  = 2,
    parameter int WALK_T = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] mode,
    input  logic [7:0] green_a,
    input  logic [7:0] green_b,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       a_r,
    output logic       a_y,
    output logic       a_g,
    output logic       b_r,
    output logic       b_y,
    output logic       b_g,
    output logic       walk,
    output logic [7:0] count
);

    typedef enum logic [3:0] {
        A_GRN, A_YEL, AR1, B_GRN, B_YEL, AR2, PED, FLASH, HOLD
    } state_t;

    // Zero durations load 1 so that every timed phase lasts at least one tick.
    localparam logic [7:0] YEL_C  = (YEL_T  == 0) ? 8'd1 : 8'(YEL_T);
    localparam logic [7:0] CLR_C  = (CLR_T  == 0) ? 8'd1 : 8'(CLR_T);
    localparam logic [7:0] WALK_C = (WALK_T == 0) ? 8'd1 : 8'(WALK_T);

    function automatic logic [7:0] load_dur(input logic [7:0] d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

    state_t     state, state_nxt;
    logic [7:0] count_nxt;
    logic       flash, flash_nxt;
    logic       pend, pend_nxt;
    logic       ack_nxt;
    logic [6:0] lamp_nxt;
    logic       night, hold_m, normal, expire;

    // Mode 11 behaves as normal operation.
    assign night  = (mode == 2'b01);
    assign hold_m = (mode == 2'b10);
    assign normal = !night && !hold_m;
    assign expire = (count <= 8'd1);

    // Next-state, count, flash bit, pending latch and ack pulse.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        flash_nxt = flash;
        if (tick) begin
            case (state)
                A_GRN: begin
                    if (!normal || expire) begin
                        state_nxt = A_YEL;
                        count_nxt = YEL_C;
                    end else begin
                        count_nxt = count - 8'd1;
                    end
                end
                A_YEL: begin
                    if (expire) begin
                        state_nxt = AR1;
                        count_nxt = CLR_C;
                    end else begin
                        count_nxt = count - 8'd1;
                    end
                end
                AR1: begin
                    if (!expire) begin
                        count_nxt = count - 8'd1;
                    end else if (night) begin
                        state_nxt = FLASH;
                    end else if (hold_m) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = B_GRN;
                        count_nxt = load_dur(green_b);
                    end
                end
                B_GRN: begin
                    if (!normal || expire) begin
                        state_nxt = B_YEL;
                        count_nxt = YEL_C;
                    end else begin
                        count_nxt = count - 8'd1;
                    end
                end
                B_YEL: begin
                    if (expire) begin
                        state_nxt = AR2;
                        count_nxt = CLR_C;
                    end else begin
                        count_nxt = count - 8'd1;
                    end
                end
                AR2: begin
                    if (!expire) begin
                        count_nxt = count - 8'd1;
                    end else if (night) begin
                        state_nxt = FLASH;
                    end else if (hold_m) begin
                        state_nxt = HOLD;
                    end else if (pend) begin
                        state_nxt = PED;
                        count_nxt = WALK_C;
                    end else begin
                        state_nxt = A_GRN;
                        count_nxt = load_dur(green_a);
                    end
                end
                PED: begin
                    if (expire) begin
                        state_nxt = A_GRN;
                        count_nxt = load_dur(green_a);
                    end else begin
                        count_nxt = count - 8'd1;
                    end
                end
                FLASH: begin
                    if (normal) begin
                        state_nxt = AR2;
                        count_nxt = CLR_C;
                    end else if (hold_m) begin
                        state_nxt = HOLD;
                    end else begin
                        flash_nxt = !flash;
                    end
                end
                HOLD: begin
                    if (normal) begin
                        state_nxt = AR2;
                        count_nxt = CLR_C;
                    end else if (night) begin
                        state_nxt = FLASH;
                    end
                end
                default: begin
                    state_nxt = AR2;
                    count_nxt = CLR_C;
                end
            endcase

            // Untimed states show zero; flash always starts dark.
            if ((state_nxt == FLASH) || (state_nxt == HOLD)) begin
                count_nxt = 8'd0;
            end
            if ((state_nxt == FLASH) && (state != FLASH)) begin
                flash_nxt = 1'b0;
            end
        end

        // A request in the entry clk survives the clear.
        pend_nxt = pend;
        if (((state_nxt == PED) && (state != PED)) ||
            ((state_nxt == FLASH) && (state != FLASH))) begin
            pend_nxt = 1'b0;
        end
        if (ped_req) begin
            pend_nxt = 1'b1;
        end

        ack_nxt = (state_nxt == PED) && (state != PED);
    end

    // Lamp decode from the next state, packed {a_r,a_y,a_g,b_r,b_y,b_g,walk}.
    always_comb begin
        lamp_nxt = 7'b1001000;
        case (state_nxt)
            A_GRN:   lamp_nxt = 7'b0011000;
            A_YEL:   lamp_nxt = 7'b0101000;
            B_GRN:   lamp_nxt = 7'b1000010;
            B_YEL:   lamp_nxt = 7'b1000100;
            PED:     lamp_nxt = 7'b1001001;
            FLASH:   lamp_nxt = {1'b0, flash_nxt, 2'b00, flash_nxt, 2'b00};
            default: lamp_nxt = 7'b1001000;
        endcase
    end

    // State and output registers; reset lands in all-red clearance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= AR2;
            count   <= CLR_C;
            flash   <= 1'b0;
            pend    <= 1'b0;
            ped_ack <= 1'b0;
            {a_r, a_y, a_g, b_r, b_y, b_g, walk} <= 7'b1001000;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            flash   <= flash_nxt;
            pend    <= pend_nxt;
            ped_ack <= ack_nxt;
            {a_r, a_y, a_g, b_r, b_y, b_g, walk} <= lamp_nxt;
        end
    end

endmodule

// File: tb/tb_intersection_sequencer.sv
module tb_intersection_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] mode;
    logic [7:0] green_a;
    logic [7:0] green_b;
    logic       ped_req;
    logic       ped_ack;
    logic       a_r, a_y, a_g, b_r, b_y, b_g, walk;
    logic [7:0] count;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [6:0] L_AG  = 7'b0011000;
    localparam logic [6:0] L_AY  = 7'b0101000;
    localparam logic [6:0] L_AR  = 7'b1001000;
    localparam logic [6:0] L_BG  = 7'b1000010;
    localparam logic [6:0] L_BY  = 7'b1000100;
    localparam logic [6:0] L_PED = 7'b1001001;
    localparam logic [6:0] L_FON = 7'b0100100;
    localparam logic [6:0] L_OFF = 7'b0000000;

    wire [6:0] lamps = {a_r, a_y, a_g, b_r, b_y, b_g, walk};

    intersection_sequencer #(.YEL_T(5), .CLR_T(2), .WALK_T(10)) dut (
        .clk(clk), .rst(rst), .tick(tick), .mode(mode),
        .green_a(green_a), .green_b(green_b), .ped_req(ped_req),
        .ped_ack(ped_ack), .a_r(a_r), .a_y(a_y), .a_g(a_g),
        .b_r(b_r), .b_y(b_y), .b_g(b_g), .walk(walk), .count(count)
    );

    always #5 clk = ~clk;

    // One tick pulse spanning exactly one rising edge; returns on a falling edge.
    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic pulse_ped();
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; tick = 1'b0; mode = 2'b00; ped_req = 1'b0;
        green_a = 8'd8; green_b = 8'd6;
        #23;
        n_total++;
        if ({lamps, count} !== {L_AR, 8'd2}) $display("FAIL reset_state lamps=%b count=%0d expected lamps=%b count=2", lamps, count, L_AR);
        else n_pass++;
        n_total++;
        if (ped_ack !== 1'b0) $display("FAIL reset_ack ped_ack=%b expected 0", ped_ack);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({lamps, count} !== {L_AR, 8'd2}) $display("FAIL reset_hold lamps=%b count=%0d expected lamps=%b count=2", lamps, count, L_AR);
        else n_pass++;
    endtask

    // Full 28-tick cycle starting from AR2 count 2, checked every tick.
    task automatic test_normal_cycle();
        int         dur [6];
        logic [6:0] lmp [6];
        int idx;
        int cnt;
        dur = '{8, 5, 2, 6, 5, 2};
        lmp = '{L_AG, L_AY, L_AR, L_BG, L_BY, L_AR};
        idx = 5;
        cnt = 2;
        for (int t = 1; t <= 28; t++) begin
            if (cnt > 1) cnt--;
            else begin
                idx = (idx + 1) % 6;
                cnt = dur[idx];
            end
            do_tick();
            n_total++;
            if ({lamps, count} !== {lmp[idx], 8'(cnt)})
                $display("FAIL normal_tick%0d lamps=%b count=%0d expected lamps=%b count=%0d", t, lamps, count, lmp[idx], cnt);
            else n_pass++;
        end
    endtask

    task automatic test_ped();
        tick_n(17);
        n_total++;
        if ({lamps, count} !== {L_BG, 8'd6}) $display("FAIL ped_bgrn lamps=%b count=%0d expected lamps=%b count=6", lamps, count, L_BG);
        else n_pass++;
        pulse_ped();
        tick_n(6 + 5 + 1);
        n_total++;
        if ({lamps, count} !== {L_AR, 8'd1}) $display("FAIL ped_ar2 lamps=%b count=%0d expected lamps=%b count=1", lamps, count, L_AR);
        else n_pass++;
        do_tick();
        n_total++;
        if ({lamps, count, ped_ack} !== {L_PED, 8'd10, 1'b1}) $display("FAIL ped_entry lamps=%b count=%0d ack=%b expected lamps=%b count=10 ack=1", lamps, count, ped_ack, L_PED);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (ped_ack !== 1'b0) $display("FAIL ped_ack_pulse ped_ack=%b expected 0", ped_ack);
        else n_pass++;
        tick_n(9);
        n_total++;
        if ({lamps, count} !== {L_PED, 8'd1}) $display("FAIL ped_last lamps=%b count=%0d expected lamps=%b count=1", lamps, count, L_PED);
        else n_pass++;
        do_tick();
        n_total++;
        if ({lamps, count} !== {L_AG, 8'd8}) $display("FAIL ped_exit lamps=%b count=%0d expected lamps=%b count=8", lamps, count, L_AG);
        else n_pass++;
        tick_n(28);
        n_total++;
        if ({lamps, count} !== {L_AG, 8'd8}) $display("FAIL ped_once lamps=%b count=%0d expected lamps=%b count=8", lamps, count, L_AG);
        else n_pass++;
    endtask

    task automatic test_night_flash();
        tick_n(3);
        mode = 2'b01;
        do_tick();
        n_total++;
        if ({lamps, count} !== {L_AY, 8'd5}) $display("FAIL flash_trunc lamps=%b count=%0d expected lamps=%b count=5", lamps, count, L_AY);
        else n_pass++;
        tick_n(5);
        n_total++;
        if ({lamps, count} !== {L_AR, 8'd2}) $display("FAIL flash_ar1 lamps=%b count=%0d expected lamps=%b count=2", lamps, count, L_AR);
        else n_pass++;
        tick_n(2);
        n_total++;
        if ({lamps, count} !== {L_OFF, 8'd0}) $display("FAIL flash_entry lamps=%b count=%0d expected lamps=%b count=0", lamps, count, L_OFF);
        else n_pass++;
        do_tick();
        n_total++;
        if ({lamps, count} !== {L_FON, 8'd0}) $display("FAIL flash_on lamps=%b count=%0d expected lamps=%b count=0", lamps, count, L_FON);
        else n_pass++;
        do_tick();
        n_total++;
        if (lamps !== L_OFF) $display("FAIL flash_off lamps=%b expected %b", lamps, L_OFF);
        else n_pass++;
        mode = 2'b00;
        do_tick();
        n_total++;
        if ({lamps, count} !== {L_AR, 8'd2}) $display("FAIL flash_exit lamps=%b count=%0d expected lamps=%b count=2", lamps, count, L_AR);
        else n_pass++;
        tick_n(2);
        n_total++;
        if ({lamps, count} !== {L_AG, 8'd8}) $display("FAIL flash_agrn lamps=%b count=%0d expected lamps=%b count=8", lamps, count, L_AG);
        else n_pass++;
    endtask

    task automatic test_green_zero_and_freeze();
        green_a = 8'd0;
        tick_n(8 + 5 + 2 + 6 + 1);
        n_total++;
        if ({lamps, count} !== {L_BY, 8'd4}) $display("FAIL freeze_pre lamps=%b count=%0d expected lamps=%b count=4", lamps, count, L_BY);
        else n_pass++;
        repeat (100) @(negedge clk);
        n_total++;
        if ({lamps, count} !== {L_BY, 8'd4}) $display("FAIL freeze_hold lamps=%b count=%0d expected lamps=%b count=4", lamps, count, L_BY);
        else n_pass++;
        tick_n(4 + 2);
        n_total++;
        if ({lamps, count} !== {L_AG, 8'd1}) $display("FAIL zero_green lamps=%b count=%0d expected lamps=%b count=1", lamps, count, L_AG);
        else n_pass++;
        do_tick();
        n_total++;
        if ({lamps, count} !== {L_AY, 8'd5}) $display("FAIL zero_expire lamps=%b count=%0d expected lamps=%b count=5", lamps, count, L_AY);
        else n_pass++;
        green_a = 8'd8;
    endtask

    task automatic test_reset_mid();
        tick_n(5 + 2 + 6 + 5 + 2 + 5);
        n_total++;
        if ({lamps, count} !== {L_AG, 8'd3}) $display("FAIL rstmid_pre lamps=%b count=%0d expected lamps=%b count=3", lamps, count, L_AG);
        else n_pass++;
        pulse_ped();
        #3 rst = 1'b0;
        #1;
        n_total++;
        if ({lamps, count} !== {L_AR, 8'd2}) $display("FAIL rstmid_async lamps=%b count=%0d expected lamps=%b count=2", lamps, count, L_AR);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        do_tick();
        n_total++;
        if ({lamps, count} !== {L_AR, 8'd1}) $display("FAIL rstmid_first lamps=%b count=%0d expected lamps=%b count=1", lamps, count, L_AR);
        else n_pass++;
        do_tick();
        n_total++;
        if ({lamps, count} !== {L_AG, 8'd8}) $display("FAIL rstmid_pend lamps=%b count=%0d expected lamps=%b count=8", lamps, count, L_AG);
        else n_pass++;
    endtask

    task automatic test_hold();
        tick_n(8 + 5 + 2);
        mode = 2'b10;
        do_tick();
        n_total++;
        if ({lamps, count} !== {L_BY, 8'd5}) $display("FAIL hold_trunc lamps=%b count=%0d expected lamps=%b count=5", lamps, count, L_BY);
        else n_pass++;
        tick_n(5 + 2);
        n_total++;
        if ({lamps, count} !== {L_AR, 8'd0}) $display("FAIL hold_entry lamps=%b count=%0d expected lamps=%b count=0", lamps, count, L_AR);
        else n_pass++;
        mode = 2'b01;
        do_tick();
        n_total++;
        if ({lamps, count} !== {L_OFF, 8'd0}) $display("FAIL hold_to_flash lamps=%b count=%0d expected lamps=%b count=0", lamps, count, L_OFF);
        else n_pass++;
        mode = 2'b10;
        do_tick();
        n_total++;
        if ({lamps, count} !== {L_AR, 8'd0}) $display("FAIL flash_to_hold lamps=%b count=%0d expected lamps=%b count=0", lamps, count, L_AR);
        else n_pass++;
        pulse_ped();
        tick_n(2);
        mode = 2'b00;
        do_tick();
        n_total++;
        if ({lamps, count} !== {L_AR, 8'd2}) $display("FAIL hold_exit lamps=%b count=%0d expected lamps=%b count=2", lamps, count, L_AR);
        else n_pass++;
        tick_n(2);
        n_total++;
        if ({lamps, count, ped_ack} !== {L_PED, 8'd10, 1'b1}) $display("FAIL hold_ped lamps=%b count=%0d ack=%b expected lamps=%b count=10 ack=1", lamps, count, ped_ack, L_PED);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_ped();
        test_night_flash();
        test_green_zero_and_freeze();
        test_reset_mid();
        test_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
